// File: rtl/vga_pkg.sv
// Shared VGA mode constants and elaboration-time helpers.
package vga_pkg;

  // ceil(log2(v)); returns 1 for v <= 2 so every counter has at least one bit
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // 640x480 @ 60 Hz, 25 MHz pixel clock, negative syncs
  localparam int   M640_H_ACTIVE = 640;
  localparam int   M640_H_FP     = 16;
  localparam int   M640_H_SYNC   = 96;
  localparam int   M640_H_BP     = 48;
  localparam int   M640_V_ACTIVE = 480;
  localparam int   M640_V_FP     = 10;
  localparam int   M640_V_SYNC   = 2;
  localparam int   M640_V_BP     = 33;
  localparam logic M640_HS_POL   = 1'b0;
  localparam logic M640_VS_POL   = 1'b0;

  // 800x600 @ 60 Hz, 40 MHz pixel clock, positive syncs
  localparam int   M800_H_ACTIVE = 800;
  localparam int   M800_H_FP     = 40;
  localparam int   M800_H_SYNC   = 128;
  localparam int   M800_H_BP     = 88;
  localparam int   M800_V_ACTIVE = 600;
  localparam int   M800_V_FP     = 1;
  localparam int   M800_V_SYNC   = 4;
  localparam int   M800_V_BP     = 23;
  localparam logic M800_HS_POL   = 1'b1;
  localparam logic M800_VS_POL   = 1'b1;

endpackage

// File: rtl/vga_timing_gen_pix_strobe_div.sv
// Pixel strobe divider: one-cycle strobe every CLK_DIV board clocks.
module pix_strobe_div
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_stb
);

  localparam int            DW     = clog2(CLK_DIV);
  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] d;

  // Free-running 0..CLK_DIV-1 counter; with CLK_DIV=1 it stays at 0
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)         d <= '0;
    else if (d == D_LAST) d <= '0;
    else                  d <= d + 1'b1;
  end

  // Strobe on the last board clock of each pixel (constant 1 when CLK_DIV=1)
  assign o_stb = (d == D_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: x/y counters advanced by the pixel strobe,
// with sync, active-video and line/frame event decodes from the same
// registered state so all outputs are mutually skew-free.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   CLK_DIV  = 4,
  parameter int   H_ACTIVE = M640_H_ACTIVE,
  parameter int   H_FP     = M640_H_FP,
  parameter int   H_SYNC   = M640_H_SYNC,
  parameter int   H_BP     = M640_H_BP,
  parameter int   V_ACTIVE = M640_V_ACTIVE,
  parameter int   V_FP     = M640_V_FP,
  parameter int   V_SYNC   = M640_V_SYNC,
  parameter int   V_BP     = M640_V_BP,
  parameter logic HS_POL   = M640_HS_POL,
  parameter logic VS_POL   = M640_VS_POL,
  localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  XW       = clog2(H_TOTAL),
  localparam int  YW       = clog2(V_TOTAL)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  output logic          o_pix_stb,
  output logic          o_hs,
  output logic          o_vs,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_active,
  output logic          o_line_end,
  output logic          o_frame_end,
  output logic          o_active_end
);

  // Decode points as inclusive bounds so no constant ever needs TOTAL itself
  localparam logic [XW-1:0] X_LAST     = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(V_TOTAL - 1);
  localparam logic [XW-1:0] X_ACT_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_ACT_LAST = YW'(V_ACTIVE - 1);
  localparam logic [XW-1:0] HS_FIRST   = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_LAST    = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [YW-1:0] VS_FIRST   = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_LAST    = YW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic          stb;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          x_last;
  logic          y_last;

  pix_strobe_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_stb   (stb)
  );

  assign x_last = (x == X_LAST);
  assign y_last = (y == Y_LAST);

  // Raster position advances once per pixel; x and y wrap together at frame end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x <= '0;
      y <= '0;
    end else if (stb) begin
      if (x_last) begin
        x <= '0;
        y <= y_last ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // Sync, active and event decodes straight from registered x/y/strobe
  always_comb begin
    o_pix_stb    = stb;
    o_x          = x;
    o_y          = y;
    o_hs         = ~HS_POL;
    o_vs         = ~VS_POL;
    if ((x >= HS_FIRST) && (x <= HS_LAST)) o_hs = HS_POL;
    if ((y >= VS_FIRST) && (y <= VS_LAST)) o_vs = VS_POL;
    o_active     = (x <= X_ACT_LAST) && (y <= Y_ACT_LAST);
    o_line_end   = stb & x_last;
    o_frame_end  = stb & x_last & y_last;
    o_active_end = stb & (x == X_ACT_LAST) & (y == Y_ACT_LAST);
  end

endmodule
